// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared encodings, digit limits and count type for the stopwatch core
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  localparam int HUND_L  = 10;
  localparam int TENTH_L = 10;
  localparam int SECU_L  = 10;
  localparam int SECT_L  = 6;

  localparam int BCD_W  = 4;
  localparam int SECT_W = 3;

  typedef struct packed {
    logic [SECT_W-1:0] sect;
    logic [BCD_W-1:0]  secu;
    logic [BCD_W-1:0]  tenth;
    logic [BCD_W-1:0]  hund;
  } count_t;

  // sec_tens only needs 3 bits internally; the display expects a full nibble
  function automatic logic [4*BCD_W-1:0] to_digits(input count_t c);
    return {{(BCD_W-SECT_W){1'b0}}, c.sect, c.secu, c.tenth, c.hund};
  endfunction

endpackage

// File: rtl/lim_inc.sv
// rtl/lim_inc.sv - modulo-L digit incrementor with carry in/out
module lim_inc #(
  parameter int W = 4,
  parameter int L = 10
) (
  input  logic [W-1:0] a,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam logic [W:0] LIM = (W+1)'(L);

  // out-of-range input collapses to 0 so the chain self-heals
  always_comb begin
    sum = a;
    co  = 1'b0;
    if ({1'b0, a} >= LIM) begin
      sum = '0;
    end else if (ci) begin
      if ({1'b0, a} == LIM - 1'b1) begin
        sum = '0;
        co  = 1'b1;
      end else begin
        sum = a + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a single-cycle count tick
module tick_prescaler #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  // gated by en so a phase frozen at LAST cannot fire while paused
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - run/pause/lap/clear engine driving the SS.HH digit chain
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_stop,
  input  logic                 clear,
  input  logic                 lap,
  output logic [4*BCD_W-1:0]   digits,
  output logic                 running,
  output logic                 lap_active,
  output logic                 wrap
);

  logic [1:0] state, state_nx;
  count_t     cnt, cnt_nx, snap;
  logic       tick, co_h, co_t, co_u, co_s;
  logic       counting, zero_cnt, take_snap;

  assign counting  = (state == ST_RUN) || (state == ST_LAP);
  assign zero_cnt  = (state == ST_PAUSE) && clear;
  assign take_snap = (state == ST_RUN) && lap && !start_stop;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (counting),
    .clr  (zero_cnt),
    .tick (tick)
  );

  lim_inc #(.W(BCD_W),  .L(HUND_L))  u_hund  (.a(cnt.hund),  .ci(tick), .sum(cnt_nx.hund),  .co(co_h));
  lim_inc #(.W(BCD_W),  .L(TENTH_L)) u_tenth (.a(cnt.tenth), .ci(co_h), .sum(cnt_nx.tenth), .co(co_t));
  lim_inc #(.W(BCD_W),  .L(SECU_L))  u_secu  (.a(cnt.secu),  .ci(co_t), .sum(cnt_nx.secu),  .co(co_u));
  lim_inc #(.W(SECT_W), .L(SECT_L))  u_sect  (.a(cnt.sect),  .ci(co_u), .sum(cnt_nx.sect),  .co(co_s));

  // clear outranks start_stop in PAUSE; start_stop outranks lap elsewhere
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start_stop) state_nx = ST_RUN;
      ST_RUN:   if (start_stop) state_nx = ST_PAUSE;
                else if (lap)   state_nx = ST_LAP;
      ST_LAP:   if (start_stop) state_nx = ST_PAUSE;
                else if (lap)   state_nx = ST_RUN;
      ST_PAUSE: if (clear)      state_nx = ST_IDLE;
                else if (start_stop) state_nx = ST_RUN;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      snap  <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      wrap  <= tick && co_s;
      if (zero_cnt) begin
        cnt <= '0;
      end else if (tick) begin
        cnt <= cnt_nx;
      end
      if (take_snap) begin
        snap <= cnt;
      end
    end
  end

  assign digits     = to_digits((state == ST_LAP) ? snap : cnt);
  assign running    = counting;
  assign lap_active = (state == ST_LAP);

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core with TICK_DIV=4
module tb_stopwatch_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        lap_active;
  logic        wrap;

  always #5 clk = ~clk;

  stopwatch_core #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .digits    (digits),
    .running   (running),
    .lap_active(lap_active),
    .wrap      (wrap)
  );

  typedef struct {
    string       name;
    logic [15:0] d;
    logic        r;
    logic        l;
    logic        w;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  event pushed;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic expect_out(input string name, input logic [15:0] d,
                            input logic r, input logic l, input logic w);
    exp_t e;
    e.name = name; e.d = d; e.r = r; e.l = l; e.w = w;
    sb.push_back(e);
    ->pushed;
  endtask

  initial begin : monitor
    forever begin
      @(pushed);
      while (sb.size() > 0) begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (digits !== mon_e.d || running !== mon_e.r ||
            lap_active !== mon_e.l || wrap !== mon_e.w) begin
          n_bad++;
          $display("FAIL %s: got digits=%h running=%b lap_active=%b wrap=%b, want digits=%h running=%b lap_active=%b wrap=%b",
                   mon_e.name, digits, running, lap_active, wrap,
                   mon_e.d, mon_e.r, mon_e.l, mon_e.w);
        end
      end
    end
  end

  // all stimulus lives on falling edges; each call starts and ends at one
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic s, input logic c, input logic l);
    start_stop = s; clear = c; lap = l;
    @(negedge clk);
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    cycles(2);
    reset = 1'b0;
    expect_out("reset_state", 16'h0000, 1'b0, 1'b0, 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    cycles(37 * 4);
    expect_out("run_00.37", 16'h0037, 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 expect_out("async_reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    cycles(1);
    reset = 1'b0;

    pulse(1'b1, 1'b0, 1'b0);
    cycles(39);
    expect_out("run_00.09", 16'h0009, 1'b1, 1'b0, 1'b0);
    cycles(1);
    expect_out("carry_00.10", 16'h0010, 1'b1, 1'b0, 1'b0);
    cycles(989 * 4);
    expect_out("run_09.99", 16'h0999, 1'b1, 1'b0, 1'b0);
    cycles(4);
    expect_out("carry_10.00", 16'h1000, 1'b1, 1'b0, 1'b0);
    cycles(4999 * 4);
    expect_out("run_59.99", 16'h5999, 1'b1, 1'b0, 1'b0);
    cycles(4);
    expect_out("wrap_00.00", 16'h0000, 1'b1, 1'b0, 1'b1);
    cycles(1);
    expect_out("wrap_one_cycle", 16'h0000, 1'b1, 1'b0, 1'b0);
    cycles(3);
    expect_out("after_wrap_00.01", 16'h0001, 1'b1, 1'b0, 1'b0);

    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    cycles(123 * 4);
    expect_out("run_01.23", 16'h0123, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    expect_out("lap_enter", 16'h0123, 1'b1, 1'b1, 1'b0);
    cycles(200);
    expect_out("lap_hold_mid", 16'h0123, 1'b1, 1'b1, 1'b0);
    cycles(106);
    expect_out("lap_hold_end", 16'h0123, 1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    expect_out("lap_release_02.00", 16'h0200, 1'b1, 1'b0, 1'b0);

    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    cycles(50 * 4);
    expect_out("run_00.50", 16'h0050, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    expect_out("start_beats_lap", 16'h0050, 1'b0, 1'b0, 1'b0);
    cycles(40);
    expect_out("pause_hold", 16'h0050, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    expect_out("lap_ignored_pause", 16'h0050, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    expect_out("clear_beats_start", 16'h0000, 1'b0, 1'b0, 1'b0);
    cycles(8);
    expect_out("idle_stays", 16'h0000, 1'b0, 1'b0, 1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    cycles(20);
    expect_out("restart_00.05", 16'h0005, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    expect_out("clear_ignored_run", 16'h0005, 1'b1, 1'b0, 1'b0);
    cycles(3);
    expect_out("run_00.06", 16'h0006, 1'b1, 1'b0, 1'b0);
    cycles(2);
    pulse(1'b1, 1'b0, 1'b0);
    cycles(10);
    expect_out("pause_partial", 16'h0006, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    expect_out("resume", 16'h0006, 1'b1, 1'b0, 1'b0);
    cycles(1);
    expect_out("resume_partial_tick", 16'h0007, 1'b1, 1'b0, 1'b0);

    #1;
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
